// File: rtl/partition_table_engine.sv
// ---------------------------------------------------------------------------
// partition_table_engine
//
// Holds a table of up to MAX_MODULES disjoint region bitmasks and executes
// PNEW / PSPLIT / PMERGE requests. Each request walks the whole table, one
// slot per cycle. The walk collects:
//   - overlap with the request region
//   - the first slot that exactly matches the request region
//   - the lowest free slot
// A single commit cycle then applies the table and mu updates. After that the
// response is offered on a valid/ready channel.
//
// Latency: the request is accepted at edge T and rsp_valid rises at edge
// T+MAX_MODULES+2 for every opcode. The updated table and mu counters are
// already visible by then.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   op_valid/ready    request handshake (ready only while idle)
//   op_code           0x00 PNEW, 0x01 PSPLIT, 0x02 PMERGE
//   op_region         PNEW region / PSPLIT mask
//   op_id_a, op_id_b  PSPLIT module / PMERGE m1, PMERGE m2
//   rsp_valid/ready   response handshake, rsp_* held until accepted
//   rsp_status        0 OK,1 BAD_OPCODE,2 BAD_ID,3 OVERLAP,4 EMPTY,5 FULL
//   rsp_id, rsp_id2   result module, PSPLIT new slot (else 0)
//   valid_mask        slot occupancy, num_modules its popcount
//   mu_discovery      saturating discovery cost
//   mu_execution      saturating execution cost
//   mu_cost           saturating sum of the two mu counters
//   partitions        slot i at [i*REGION_WIDTH +: REGION_WIDTH], 0 when free
// ---------------------------------------------------------------------------
module partition_table_engine #(
  parameter int MAX_MODULES  = 8,
  parameter int REGION_WIDTH = 64,
  parameter int MU_WIDTH     = 32,
  localparam int ID_W        = $clog2(MAX_MODULES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 op_valid,
  output logic                                 op_ready,
  input  logic [7:0]                           op_code,
  input  logic [REGION_WIDTH-1:0]              op_region,
  input  logic [ID_W-1:0]                      op_id_a,
  input  logic [ID_W-1:0]                      op_id_b,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [2:0]                           rsp_status,
  output logic [ID_W-1:0]                      rsp_id,
  output logic [ID_W-1:0]                      rsp_id2,
  output logic [MAX_MODULES-1:0]               valid_mask,
  output logic [ID_W:0]                        num_modules,
  output logic [MU_WIDTH-1:0]                  mu_discovery,
  output logic [MU_WIDTH-1:0]                  mu_execution,
  output logic [MU_WIDTH-1:0]                  mu_cost,
  output logic [MAX_MODULES*REGION_WIDTH-1:0]  partitions
);

  localparam int PC_W  = $clog2(REGION_WIDTH + 1);
  localparam int SUM_W = ((MU_WIDTH > PC_W) ? MU_WIDTH : PC_W) + 1;

  localparam logic [7:0] OP_PNEW   = 8'h00;
  localparam logic [7:0] OP_PSPLIT = 8'h01;
  localparam logic [7:0] OP_PMERGE = 8'h02;

  localparam logic [2:0] ST_OK         = 3'd0;
  localparam logic [2:0] ST_BAD_OPCODE = 3'd1;
  localparam logic [2:0] ST_BAD_ID     = 3'd2;
  localparam logic [2:0] ST_OVERLAP    = 3'd3;
  localparam logic [2:0] ST_EMPTY      = 3'd4;
  localparam logic [2:0] ST_FULL       = 3'd5;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;

  state_t state, next_state;

  logic [7:0]              cur_code;
  logic [REGION_WIDTH-1:0] cur_region;
  logic [ID_W-1:0]         cur_a, cur_b;
  logic [ID_W-1:0]         scan_idx;
  logic                    acc_overlap, acc_match, acc_free;
  logic [ID_W-1:0]         match_idx, free_idx;

  logic [REGION_WIDTH-1:0] tbl [MAX_MODULES];
  logic [REGION_WIDTH-1:0] nxt_tbl [MAX_MODULES];
  logic [MAX_MODULES-1:0]  table_valid, nxt_valid;
  logic [MU_WIDTH-1:0]     disc_q, exec_q, nxt_disc, nxt_exec;

  logic [2:0]              dec_status;
  logic [ID_W-1:0]         dec_id, dec_id2;

  logic                    a_ok, b_ok, valid_a, valid_b;
  logic [REGION_WIDTH-1:0] reg_a, reg_b, split_keep, split_new;
  logic [MU_WIDTH:0]       cost_sum;

  function automatic logic [PC_W-1:0] popcount(input logic [REGION_WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < REGION_WIDTH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Add in a wider domain, then clamp, so the counters stick at all-ones
  // instead of wrapping. The increment can be wider than the counter.
  function automatic logic [MU_WIDTH-1:0] sat_add(input logic [MU_WIDTH-1:0] base,
                                                  input logic [PC_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(base) + SUM_W'(inc);
    if (s > SUM_W'({MU_WIDTH{1'b1}})) return '1;
    return s[MU_WIDTH-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and request readiness
  always_comb begin
    next_state = state;
    op_ready   = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) next_state = SCAN;
      end
      SCAN:   if (scan_idx == ID_W'(MAX_MODULES - 1)) next_state = COMMIT;
      COMMIT: next_state = RESP;
      RESP:   if (rsp_valid && rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand views used by the commit decision. Ids beyond the table size
  // count as free slots, so they report BAD_ID.
  always_comb begin
    a_ok       = ({1'b0, cur_a} < (ID_W+1)'(MAX_MODULES));
    b_ok       = ({1'b0, cur_b} < (ID_W+1)'(MAX_MODULES));
    valid_a    = a_ok && table_valid[cur_a];
    valid_b    = b_ok && table_valid[cur_b];
    reg_a      = a_ok ? tbl[cur_a] : '0;
    reg_b      = b_ok ? tbl[cur_b] : '0;
    split_keep = reg_a & cur_region;
    split_new  = reg_a & ~cur_region;
  end

  // Commit decision. The checks are ordered so that the status precedence
  // falls out of the if/else chain. The proposed table and mu values
  // differ from the current ones only on the OK paths.
  always_comb begin
    nxt_tbl    = tbl;
    nxt_valid  = table_valid;
    nxt_disc   = disc_q;
    nxt_exec   = exec_q;
    dec_status = ST_OK;
    dec_id     = '0;
    dec_id2    = '0;
    case (cur_code)
      OP_PNEW: begin
        if (cur_region == '0) begin
          dec_status = ST_EMPTY;
        end else if (acc_match) begin
          dec_id = match_idx;
        end else if (acc_overlap) begin
          dec_status = ST_OVERLAP;
        end else if (!acc_free) begin
          dec_status = ST_FULL;
        end else begin
          dec_id              = free_idx;
          nxt_tbl[free_idx]   = cur_region;
          nxt_valid[free_idx] = 1'b1;
          nxt_disc            = sat_add(disc_q, popcount(cur_region));
        end
      end
      OP_PSPLIT: begin
        if (!valid_a) begin
          dec_status = ST_BAD_ID;
        end else if (split_keep == '0 || split_new == '0) begin
          dec_status = ST_EMPTY;
        end else if (!acc_free) begin
          dec_status = ST_FULL;
        end else begin
          dec_id              = cur_a;
          dec_id2             = free_idx;
          nxt_tbl[cur_a]      = split_keep;
          nxt_tbl[free_idx]   = split_new;
          nxt_valid[free_idx] = 1'b1;
          nxt_exec            = sat_add(exec_q, popcount(reg_a));
        end
      end
      OP_PMERGE: begin
        if (cur_a == cur_b || !valid_a || !valid_b) begin
          dec_status = ST_BAD_ID;
        end else begin
          dec_id           = cur_a;
          nxt_tbl[cur_a]   = reg_a | reg_b;
          nxt_tbl[cur_b]   = '0;
          nxt_valid[cur_b] = 1'b0;
          nxt_exec         = sat_add(exec_q, PC_W'(1));
        end
      end
      default: dec_status = ST_BAD_OPCODE;
    endcase
  end

  // Datapath. Latch the operands on accept and walk one slot per SCAN cycle.
  // Apply the decision in COMMIT, then raise rsp_valid one cycle into RESP.
  // Free slots are always kept at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_code    <= '0;
      cur_region  <= '0;
      cur_a       <= '0;
      cur_b       <= '0;
      scan_idx    <= '0;
      acc_overlap <= 1'b0;
      acc_match   <= 1'b0;
      acc_free    <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      for (int i = 0; i < MAX_MODULES; i++) tbl[i] <= '0;
      table_valid <= '0;
      disc_q      <= '0;
      exec_q      <= '0;
      rsp_valid   <= 1'b0;
      rsp_status  <= '0;
      rsp_id      <= '0;
      rsp_id2     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            cur_code    <= op_code;
            cur_region  <= op_region;
            cur_a       <= op_id_a;
            cur_b       <= op_id_b;
            scan_idx    <= '0;
            acc_overlap <= 1'b0;
            acc_match   <= 1'b0;
            acc_free    <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
          end
        end
        SCAN: begin
          if (table_valid[scan_idx]) begin
            if ((tbl[scan_idx] & cur_region) != '0) acc_overlap <= 1'b1;
            if (tbl[scan_idx] == cur_region && !acc_match) begin
              acc_match <= 1'b1;
              match_idx <= scan_idx;
            end
          end else if (!acc_free) begin
            acc_free <= 1'b1;
            free_idx <= scan_idx;
          end
          scan_idx <= scan_idx + ID_W'(1);
        end
        COMMIT: begin
          tbl         <= nxt_tbl;
          table_valid <= nxt_valid;
          disc_q      <= nxt_disc;
          exec_q      <= nxt_exec;
          rsp_status  <= dec_status;
          rsp_id      <= dec_id;
          rsp_id2     <= dec_id2;
        end
        RESP: begin
          if (!rsp_valid)     rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Derived status outputs
  always_comb begin
    valid_mask   = table_valid;
    mu_discovery = disc_q;
    mu_execution = exec_q;
    cost_sum     = {1'b0, disc_q} + {1'b0, exec_q};
    mu_cost      = cost_sum[MU_WIDTH] ? '1 : cost_sum[MU_WIDTH-1:0];
    num_modules  = '0;
    partitions   = '0;
    for (int i = 0; i < MAX_MODULES; i++) begin
      num_modules = num_modules + (ID_W+1)'(table_valid[i]);
      partitions[i*REGION_WIDTH +: REGION_WIDTH] = tbl[i];
    end
  end

endmodule

// File: tb/tb_partition_table_engine.sv
// ---------------------------------------------------------------------------
// tb_partition_table_engine
//
// Self-checking bench for partition_table_engine.
//
// The stimulus issues directed and randomised requests. Each issued request
// runs through a table-level reference model, and the expected response plus
// a table/mu snapshot is pushed onto a scoreboard queue.
//
// A monitor compares every cycle in which rsp_valid is high against the head
// of the queue. It pops the entry on handshake.
//
// A second small instance, with 4-bit mu counters, exercises saturation.
// ---------------------------------------------------------------------------
module tb_partition_table_engine;

  localparam int MAXM = 8;
  localparam int RW   = 64;
  localparam int IDW  = 3;
  localparam int LAT  = MAXM + 2;
  localparam longint MU_MAX = 64'hFFFF_FFFF;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 op_valid = 1'b0;
  logic                 op_ready;
  logic [7:0]           op_code = '0;
  logic [RW-1:0]        op_region = '0;
  logic [IDW-1:0]       op_id_a = '0;
  logic [IDW-1:0]       op_id_b = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [2:0]           rsp_status;
  logic [IDW-1:0]       rsp_id, rsp_id2;
  logic [MAXM-1:0]      valid_mask;
  logic [IDW:0]         num_modules;
  logic [31:0]          mu_discovery, mu_execution, mu_cost;
  logic [MAXM*RW-1:0]   partitions;

  logic        s_op_valid = 1'b0;
  logic        s_op_ready;
  logic [7:0]  s_op_code = '0;
  logic [15:0] s_op_region = '0;
  logic [0:0]  s_op_id_a = '0;
  logic [0:0]  s_op_id_b = '0;
  logic        s_rsp_valid;
  logic        s_rsp_ready = 1'b1;
  logic [2:0]  s_rsp_status;
  logic [0:0]  s_rsp_id, s_rsp_id2;
  logic [1:0]  s_valid_mask;
  logic [1:0]  s_num_modules;
  logic [3:0]  s_mu_discovery, s_mu_execution, s_mu_cost;
  logic [31:0] s_partitions;

  always #5 clk = ~clk;

  partition_table_engine dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_region(op_region), .op_id_a(op_id_a), .op_id_b(op_id_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_id(rsp_id), .rsp_id2(rsp_id2), .valid_mask(valid_mask),
    .num_modules(num_modules), .mu_discovery(mu_discovery),
    .mu_execution(mu_execution), .mu_cost(mu_cost), .partitions(partitions)
  );

  partition_table_engine #(.MAX_MODULES(2), .REGION_WIDTH(16), .MU_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst),
    .op_valid(s_op_valid), .op_ready(s_op_ready), .op_code(s_op_code),
    .op_region(s_op_region), .op_id_a(s_op_id_a), .op_id_b(s_op_id_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_status(s_rsp_status),
    .rsp_id(s_rsp_id), .rsp_id2(s_rsp_id2), .valid_mask(s_valid_mask),
    .num_modules(s_num_modules), .mu_discovery(s_mu_discovery),
    .mu_execution(s_mu_execution), .mu_cost(s_mu_cost), .partitions(s_partitions)
  );

  typedef struct {
    logic [2:0]        st;
    int                id;
    int                id2;
    logic [MAXM-1:0]   mask;
    logic [MAXM*RW-1:0] parts;
    longint            disc;
    longint            exec;
    int                acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          edge_cnt = 0;
  bit          first_sample = 1'b1;
  int          stall = 0;
  bit          rand_ready = 1'b0;

  logic [RW-1:0] m_tbl [MAXM];
  bit            m_valid [MAXM];
  longint        m_disc, m_exec;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [511:0] actual,
                             input logic [511:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic longint satAdd(input longint x, input longint y);
    return (x + y > MU_MAX) ? MU_MAX : x + y;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < MAXM; k++) begin
      m_tbl[k] = '0;
      m_valid[k] = 1'b0;
    end
    m_disc = 0;
    m_exec = 0;
  endtask

  // Table-level reference: status rules applied in precedence order
  task automatic modelOp(input logic [7:0] code, input logic [RW-1:0] r, input int a,
                         input int b, output logic [2:0] st, output int id, output int id2);
    int k_match, k_free;
    bit ov;
    logic [RW-1:0] ka, kb;
    st = 3'd0; id = 0; id2 = 0; k_match = -1; k_free = -1; ov = 1'b0;
    for (int k = 0; k < MAXM; k++) begin
      if (m_valid[k] && m_tbl[k] == r && k_match < 0) k_match = k;
      if (m_valid[k] && (m_tbl[k] & r) != 0) ov = 1'b1;
      if (!m_valid[k] && k_free < 0) k_free = k;
    end
    if (code == 8'h00) begin
      if (r == 0) st = 3'd4;
      else if (k_match >= 0) id = k_match;
      else if (ov) st = 3'd3;
      else if (k_free < 0) st = 3'd5;
      else begin
        m_tbl[k_free] = r;
        m_valid[k_free] = 1'b1;
        m_disc = satAdd(m_disc, $countones(r));
        id = k_free;
      end
    end else if (code == 8'h01) begin
      if (!m_valid[a]) st = 3'd2;
      else begin
        ka = m_tbl[a] & r;
        kb = m_tbl[a] & ~r;
        if (ka == 0 || kb == 0) st = 3'd4;
        else if (k_free < 0) st = 3'd5;
        else begin
          m_exec = satAdd(m_exec, $countones(m_tbl[a]));
          m_tbl[a] = ka;
          m_tbl[k_free] = kb;
          m_valid[k_free] = 1'b1;
          id = a;
          id2 = k_free;
        end
      end
    end else if (code == 8'h02) begin
      if (a == b || !m_valid[a] || !m_valid[b]) st = 3'd2;
      else begin
        m_tbl[a] = m_tbl[a] | m_tbl[b];
        m_tbl[b] = '0;
        m_valid[b] = 1'b0;
        m_exec = satAdd(m_exec, 1);
        id = a;
      end
    end else begin
      st = 3'd1;
    end
  endtask

  // Issue one request; when expect_rsp is set its expected outcome goes on the scoreboard
  task automatic applyStimulus(input logic [7:0] code, input logic [RW-1:0] r,
                               input int a, input int b, input bit expect_rsp);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!op_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) begin
      checkOutput("op_ready_timeout", op_ready, 1'b1);
      return;
    end
    if (expect_rsp) begin
      modelOp(code, r, a, b, e.st, e.id, e.id2);
      e.parts = '0;
      for (int k = 0; k < MAXM; k++) begin
        e.mask[k] = m_valid[k];
        if (m_valid[k]) e.parts[k*RW +: RW] = m_tbl[k];
      end
      e.disc = m_disc;
      e.exec = m_exec;
      e.acc  = edge_cnt + 1;
      sb.push_back(e);
    end
    op_code   = code;
    op_region = r;
    op_id_a   = a[IDW-1:0];
    op_id_b   = b[IDW-1:0];
    op_valid  = 1'b1;
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || !op_ready) && w < 400) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_op_ready"}, op_ready, 1'b1);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    checkOutput({tag, "_rsp_fields"}, {rsp_status, rsp_id, rsp_id2}, '0);
    checkOutput({tag, "_valid_mask"}, valid_mask, '0);
    checkOutput({tag, "_num_modules"}, num_modules, '0);
    checkOutput({tag, "_mu"}, {mu_discovery, mu_execution, mu_cost}, '0);
    checkOutput({tag, "_partitions"}, partitions, '0);
    sb.delete();
    first_sample = 1'b1;
    modelClear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [RW-1:0] genRegion();
    int w, p, k;
    logic [RW-1:0] one;
    one = 1;
    if ($urandom_range(0, 15) == 0) return '0;
    if ($urandom_range(0, 5) == 0) begin
      k = $urandom_range(0, MAXM - 1);
      if (m_valid[k]) return m_tbl[k];
    end
    w = $urandom_range(1, 8);
    p = $urandom_range(0, RW - 1);
    return ((one << w) - 1) << p;
  endfunction

  // Response-side ready: forced low for a number of valid cycles, else random or high
  always @(posedge clk) begin
    #2;
    if (stall > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) stall--;
    end else if (rand_ready) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      rsp_ready = 1'b1;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_rsp", rsp_valid, 1'b0);
      end else begin
        e = sb[0];
        if (first_sample) checkOutput("latency", edge_cnt - e.acc, LAT);
        first_sample = 1'b0;
        checkOutput("rsp_status", rsp_status, e.st);
        if (e.st == 3'd0) checkOutput("rsp_ids", {rsp_id, rsp_id2}, {e.id[IDW-1:0], e.id2[IDW-1:0]});
        checkOutput("valid_mask", valid_mask, e.mask);
        checkOutput("num_modules", num_modules, $countones(e.mask));
        checkOutput("partitions", partitions, e.parts);
        checkOutput("mu_discovery", mu_discovery, e.disc[31:0]);
        checkOutput("mu_execution", mu_execution, e.exec[31:0]);
        checkOutput("mu_cost", mu_cost, satAdd(e.disc, e.exec));
        checkOutput("op_ready_busy", op_ready, 1'b0);
        if (rsp_ready) begin
          void'(sb.pop_front());
          first_sample = 1'b1;
        end
      end
    end
  end

  task automatic satOp(input logic [7:0] code, input logic [15:0] r, input logic a);
    int w;
    w = 0;
    @(negedge clk);
    s_op_code = code;
    s_op_region = r;
    s_op_id_a = a;
    s_op_id_b = '0;
    s_op_valid = 1'b1;
    @(posedge clk);
    #1;
    s_op_valid = 1'b0;
    while (!s_rsp_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput("sat_rsp_ok", {s_rsp_valid, s_rsp_status}, {1'b1, 3'd0});
  endtask

  initial begin
    int  a, b, sel;
    bit  seen;
    logic [RW-1:0] one;
    one = 1;
    modelClear();

    doReset("reset");

    // Create, split and merge regions
    applyStimulus(8'h00, 64'h7, 0, 0, 1'b1);
    applyStimulus(8'h00, 64'h30, 0, 0, 1'b1);
    applyStimulus(8'h01, 64'h1, 0, 0, 1'b1);
    applyStimulus(8'h02, 64'h0, 1, 2, 1'b1);
    drain();
    checkOutput("t2_disc", mu_discovery, 32'd5);
    checkOutput("t2_exec", mu_execution, 32'd4);
    checkOutput("t2_cost", mu_cost, 32'd9);
    checkOutput("t2_mask", valid_mask, 8'b011);
    checkOutput("t2_slots", partitions[127:0], {64'h36, 64'h1});

    // Error paths leave the table alone; exact match returns existing id
    applyStimulus(8'h00, 64'h3, 0, 0, 1'b1);
    applyStimulus(8'h00, 64'h1, 0, 0, 1'b1);
    applyStimulus(8'h02, 64'h0, 1, 1, 1'b1);
    applyStimulus(8'h07, 64'h0, 0, 0, 1'b1);
    drain();
    checkOutput("t3_cost", mu_cost, 32'd9);
    checkOutput("t3_slots", partitions[127:0], {64'h36, 64'h1});

    // Fill the table, then FULL on PNEW and PSPLIT
    doReset("reset2");
    for (int i = 0; i < MAXM; i++) applyStimulus(8'h00, 64'h3 << (4 * i), 0, 0, 1'b1);
    drain();
    checkOutput("t4_num", num_modules, 4'd8);
    applyStimulus(8'h00, one << 40, 0, 0, 1'b1);
    applyStimulus(8'h01, 64'h1, 0, 0, 1'b1);
    drain();
    checkOutput("t4_num_after", num_modules, 4'd8);
    checkOutput("t4_disc", mu_discovery, 32'd16);

    // Response held while rsp_ready is low
    stall = 5;
    applyStimulus(8'h02, 64'h0, 0, 1, 1'b1);
    a = 0;
    while (!rsp_valid && a < 40) begin
      @(negedge clk);
      a++;
    end
    repeat (5) begin
      checkOutput("hold_valid", {rsp_valid, op_ready}, 2'b10);
      @(negedge clk);
    end
    drain();

    // Reset during SCAN aborts with no response
    applyStimulus(8'h02, 64'h0, 2, 3, 1'b0);
    repeat (2) @(negedge clk);
    doReset("midscan");
    seen = 1'b0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("no_rsp_after_rst", seen, 1'b0);

    // Randomised traffic with random response back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 19);
      a = $urandom_range(0, MAXM - 1);
      b = $urandom_range(0, MAXM - 1);
      if (sel == 0)       applyStimulus(8'($urandom_range(3, 255)), genRegion(), a, b, 1'b1);
      else if (sel <= 8)  applyStimulus(8'h00, genRegion(), a, b, 1'b1);
      else if (sel <= 13) applyStimulus(8'h01, {$urandom, $urandom}, a, b, 1'b1);
      else                applyStimulus(8'h02, '0, a, b, 1'b1);
    end
    drain();
    rand_ready = 1'b0;

    // Saturation on the 4-bit mu instance
    satOp(8'h00, 16'hFFFF, 1'b0);
    checkOutput("sat_disc", s_mu_discovery, 4'd15);
    checkOutput("sat_cost", s_mu_cost, 4'd15);
    repeat (2) @(negedge clk);
    satOp(8'h01, 16'h00FF, 1'b0);
    checkOutput("sat_exec", s_mu_execution, 4'd15);
    checkOutput("sat_cost2", s_mu_cost, 4'd15);
    checkOutput("sat_parts", s_partitions, {16'hFF00, 16'h00FF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
